// File: rtl/cmac_rx_link_supervisor.sv
// CMAC RX link supervisor: pulses the RX datapath reset, waits for PCS alignment with
// exponential back-off, debounces alignment into link_up and counts retrains.
module cmac_rx_link_supervisor #(
    parameter int unsigned ALIGN_TIMEOUT = 644531250,
    parameter int unsigned RESET_CYCLES  = 50,
    parameter int unsigned DEBOUNCE      = 1024,
    parameter int unsigned STABLE_CYCLES = 32226562,
    parameter int unsigned MAX_BACKOFF   = 4
) (
    input  logic        rx_clk,
    input  logic        rx_reset,
    input  logic        sync_rx_aligned,
    input  logic        force_retrain,
    output logic        reset_rx_datapath,
    output logic        link_up,
    output logic [2:0]  backoff_level,
    output logic [15:0] retrain_count,
    output logic [2:0]  fsm_state
);
    localparam int TW = 40;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_UP     = 3'd3
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [DW-1:0]  deb_q, deb_d;
    logic [SW-1:0]  stab_q, stab_d;
    logic [2:0]     backoff_d;
    logic [15:0]    retrain_d;
    logic           rst_dp_d, link_up_d;
    logic           retrain_evt;

    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state_q           <= ST_RESET;
            timer_q           <= TW'(RESET_CYCLES);
            deb_q             <= '0;
            stab_q            <= '0;
            backoff_level     <= '0;
            retrain_count     <= '0;
            reset_rx_datapath <= 1'b1;
            link_up           <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            deb_q             <= deb_d;
            stab_q            <= stab_d;
            backoff_level     <= backoff_d;
            retrain_count     <= retrain_d;
            reset_rx_datapath <= rst_dp_d;
            link_up           <= link_up_d;
        end
    end

    // force_retrain is checked first so it wins over timeout and alignment loss.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        deb_d       = deb_q;
        stab_d      = stab_q;
        backoff_d   = backoff_level;
        retrain_evt = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (timer_q == TW'(1)) begin
                    state_d = ST_WAIT;
                    timer_d = TW'(ALIGN_TIMEOUT) << backoff_level;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_WAIT: begin
                if (force_retrain) begin
                    state_d     = ST_RESET;
                    retrain_evt = 1'b1;
                end else if (sync_rx_aligned) begin
                    state_d = ST_SETTLE;
                    deb_d   = '0;
                end else if (timer_q == TW'(1)) begin
                    state_d = ST_RESET;
                    if (backoff_level < 3'(MAX_BACKOFF))
                        backoff_d = backoff_level + 3'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_SETTLE: begin
                if (force_retrain) begin
                    state_d     = ST_RESET;
                    retrain_evt = 1'b1;
                end else if (!sync_rx_aligned) begin
                    state_d = ST_RESET;
                end else if (deb_q == DW'(DEBOUNCE - 1)) begin
                    state_d = ST_UP;
                    stab_d  = '0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            ST_UP: begin
                if (force_retrain || !sync_rx_aligned) begin
                    state_d     = ST_RESET;
                    retrain_evt = 1'b1;
                end else if (stab_q == SW'(STABLE_CYCLES - 1)) begin
                    stab_d    = SW'(STABLE_CYCLES);
                    backoff_d = '0;
                end else if (stab_q != SW'(STABLE_CYCLES)) begin
                    stab_d = stab_q + SW'(1);
                end
            end
            default: state_d = ST_RESET;
        endcase
        if (state_d == ST_RESET && state_q != ST_RESET)
            timer_d = TW'(RESET_CYCLES);
    end

    always_comb begin
        rst_dp_d  = (state_d == ST_RESET);
        link_up_d = (state_d == ST_UP);
        retrain_d = retrain_count;
        if (retrain_evt && retrain_count != 16'hFFFF)
            retrain_d = retrain_count + 16'd1;
    end

    assign fsm_state = state_q;
endmodule

// File: tb/tb_cmac_rx_link_supervisor.sv
// Directed bench for cmac_rx_link_supervisor with short timeouts.
module tb_cmac_rx_link_supervisor;
    logic        rx_clk = 1'b0;
    logic        rx_reset;
    logic        sync_rx_aligned;
    logic        force_retrain;
    logic        reset_rx_datapath;
    logic        link_up;
    logic [2:0]  backoff_level;
    logic [15:0] retrain_count;
    logic [2:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    cmac_rx_link_supervisor #(
        .ALIGN_TIMEOUT(100), .RESET_CYCLES(5), .DEBOUNCE(8),
        .STABLE_CYCLES(50), .MAX_BACKOFF(2)
    ) dut (
        .rx_clk(rx_clk), .rx_reset(rx_reset), .sync_rx_aligned(sync_rx_aligned),
        .force_retrain(force_retrain), .reset_rx_datapath(reset_rx_datapath),
        .link_up(link_up), .backoff_level(backoff_level),
        .retrain_count(retrain_count), .fsm_state(fsm_state)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    // Counts edges until reset_rx_datapath leaves level val.
    task automatic measure(input logic val, output int n);
        n = 0;
        while (reset_rx_datapath === val && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st);
        int n = 0;
        while (fsm_state !== st && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, fsm_state, st);
    endtask

    task automatic do_reset();
        rx_reset = 1'b1;
        tick(2);
        rx_reset = 1'b0;
    endtask

    initial begin
        int n;
        rx_reset = 1'b1;
        sync_rx_aligned = 1'b0;
        force_retrain = 1'b0;
        tick(3);
        chk("rst_state", fsm_state, 0);
        chk("rst_rdp", reset_rx_datapath, 1);
        chk("rst_link", link_up, 0);
        chk("rst_backoff", backoff_level, 0);
        chk("rst_count", retrain_count, 0);
        rx_reset = 1'b0;

        // Back-off sequence with no alignment.
        measure(1'b1, n); chk("pulse0", n, 5);
        chk("wait_state", fsm_state, 1);
        measure(1'b0, n); chk("gap0", n, 100);
        chk("bo1", backoff_level, 1);
        measure(1'b1, n); chk("pulse1", n, 5);
        measure(1'b0, n); chk("gap1", n, 200);
        chk("bo2", backoff_level, 2);
        measure(1'b1, n); chk("pulse2", n, 5);
        measure(1'b0, n); chk("gap2", n, 400);
        chk("bo_sat", backoff_level, 2);
        measure(1'b1, n); chk("pulse3", n, 5);
        measure(1'b0, n); chk("gap3", n, 400);
        chk("retrain_timeouts", retrain_count, 0);

        // Alignment 3 cycles after release; link_up 8 cycles after SETTLE entry.
        do_reset();
        tick(3);
        sync_rx_aligned = 1'b1;
        wait_state("to_settle", 2);
        n = 0;
        while (!link_up && n < 100) begin
            tick();
            n++;
        end
        chk("debounce_len", n, 8);
        chk("up_state", fsm_state, 3);
        chk("up_count", retrain_count, 0);

        // Alignment glitch in SETTLE at count 5.
        sync_rx_aligned = 1'b0;
        do_reset();
        measure(1'b1, n);
        measure(1'b0, n); chk("g_gap0", n, 100);
        measure(1'b1, n);
        tick(10);
        sync_rx_aligned = 1'b1;
        wait_state("g_settle", 2);
        tick(5);
        chk("g_nolink", link_up, 0);
        sync_rx_aligned = 1'b0;
        tick();
        chk("g_state", fsm_state, 0);
        chk("g_link", link_up, 0);
        chk("g_backoff", backoff_level, 1);
        measure(1'b1, n); chk("g_pulse", n, 5);
        measure(1'b0, n); chk("g_gap1", n, 200);
        measure(1'b1, n);

        // UP at back-off 2, stable period clears it, then alignment loss.
        sync_rx_aligned = 1'b1;
        wait_state("s_up", 3);
        chk("s_bo_entry", backoff_level, 2);
        tick(49);
        chk("s_bo_49", backoff_level, 2);
        tick();
        chk("s_bo_50", backoff_level, 0);
        sync_rx_aligned = 1'b0;
        tick();
        chk("s_link_drop", link_up, 0);
        chk("s_state", fsm_state, 0);
        chk("s_count", retrain_count, 1);
        measure(1'b1, n); chk("s_pulse", n, 5);
        measure(1'b0, n); chk("s_window", n, 100);

        // force_retrain coincident with alignment loss, then a force during RESET.
        sync_rx_aligned = 1'b1;
        wait_state("f_up", 3);
        force_retrain = 1'b1;
        sync_rx_aligned = 1'b0;
        tick();
        force_retrain = 1'b0;
        chk("f_count", retrain_count, 2);
        chk("f_state", fsm_state, 0);
        tick(2);
        force_retrain = 1'b1;
        tick();
        force_retrain = 1'b0;
        chk("f_ignored", retrain_count, 2);
        measure(1'b1, n); chk("f_remain", n, 2);

        // Third retrain, then asynchronous reset while UP.
        sync_rx_aligned = 1'b1;
        wait_state("a_up0", 3);
        force_retrain = 1'b1;
        tick();
        force_retrain = 1'b0;
        wait_state("a_up1", 3);
        chk("a_count3", retrain_count, 3);
        #2 rx_reset = 1'b1;
        #1;
        chk("a_rdp", reset_rx_datapath, 1);
        chk("a_link", link_up, 0);
        chk("a_count", retrain_count, 0);
        chk("a_state", fsm_state, 0);
        tick(2);
        rx_reset = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
